// File: rtl/fb_write_scheduler.sv
// Arbitrates the single framebuffer write port between a raster clear engine and a draw requester.
// Latency 1 (draw accept -> fb_we); output slot stalls on !fb_ready and draw_ready drops while it is full.
// Clear sweeps x first then y with a colour latched at request; clear_done pulses after the last clear write is taken.
module fb_write_scheduler #(
    parameter int WIDTH   = 11,
    parameter int HACTIVE = 1280,
    parameter int VACTIVE = 640,
    parameter int COLOR_W = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_req,
    input  logic [COLOR_W-1:0] clear_color,
    output logic               clear_busy,
    output logic               clear_done,
    input  logic               draw_valid,
    input  logic [WIDTH-1:0]   draw_x,
    input  logic [WIDTH-1:0]   draw_y,
    input  logic [COLOR_W-1:0] draw_color,
    output logic               draw_ready,
    output logic               fb_we,
    output logic [WIDTH-1:0]   fb_x,
    output logic [WIDTH-1:0]   fb_y,
    output logic [COLOR_W-1:0] fb_color,
    input  logic               fb_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] X_LAST = WIDTH'(HACTIVE - 1);
    localparam logic [WIDTH-1:0] Y_LAST = WIDTH'(VACTIVE - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cx_q, cx_d;
    logic [WIDTH-1:0]   cy_q, cy_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               we_q, we_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [COLOR_W-1:0] c_q, c_d;
    logic               done_q, done_d;
    logic               slot_free;

    assign slot_free  = !we_q || fb_ready;
    assign draw_ready = (state_q == ST_IDLE) && !clear_req && slot_free;
    assign clear_busy = (state_q != ST_IDLE);
    assign clear_done = done_q;
    assign fb_we      = we_q;
    assign fb_x       = x_q;
    assign fb_y       = y_q;
    assign fb_color   = c_q;

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        color_d = color_q;
        we_d    = we_q;
        x_d     = x_q;
        y_d     = y_q;
        c_d     = c_q;
        done_d  = 1'b0;

        // A drained slot empties unless something below reloads it this cycle.
        if (slot_free) begin
            we_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    color_d = clear_color;
                    cx_d    = '0;
                    cy_d    = '0;
                end else if (draw_valid && slot_free) begin
                    we_d = 1'b1;
                    x_d  = draw_x;
                    y_d  = draw_y;
                    c_d  = draw_color;
                end
            end
            ST_CLEAR: begin
                if (slot_free) begin
                    we_d = 1'b1;
                    x_d  = cx_q;
                    y_d  = cy_q;
                    c_d  = color_q;
                    if (cx_q == X_LAST) begin
                        cx_d = '0;
                        if (cy_q == Y_LAST) begin
                            cy_d    = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            cy_d = cy_q + WIDTH'(1);
                        end
                    end else begin
                        cx_d = cx_q + WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (we_q && fb_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            color_q <= '0;
            we_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            color_q <= color_d;
            we_q    <= we_d;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            done_q  <= done_d;
        end
    end

endmodule
